// File: rtl/syscall_controller.sv
// syscall_controller
//   Handles SYSCALL instructions sitting in EX. It latches $v0/$a0, freezes
//   the front of the pipe while older instructions drain through MEM/WB,
//   issues one console print request (valid/ready), and then retires the
//   syscall with a one-cycle done pulse. EXIT parks the FSM in HALT until
//   reset. Unsupported codes retire with a sticky bad_syscall flag.
//
//   Build option: define SYSCALL_PRINT_CHAR_EN to support PRINT_CHAR (11).
//   Without it, code 11 is treated as unsupported and print_is_char is 0.
//
//   Ports
//     clk, rst_n       clock, async active-low reset
//     is_syscall       SYSCALL occupies EX
//     syscall_funct    $v0 forwarded to EX
//     syscall_param1   $a0 forwarded to EX
//     stall            freeze IF/ID/EX
//     print_valid      console request valid
//     print_ready      console accepts request
//     print_data       value to print
//     print_is_char    1 = low byte as ASCII, 0 = signed decimal
//     syscall_done     one-cycle retire pulse
//     halted           program exited (sticky)
//     bad_syscall      unsupported code seen (sticky)
//
//   state | meaning
//   IDLE  | waiting for a syscall in EX
//   DRAIN | older instructions retiring, counter running
//   ISSUE | print request presented to console
//   DONE  | syscall retires, pipe released
//   HALT  | program exited, frozen until reset

module syscall_controller #(
  parameter int DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        is_syscall,
  input  logic [31:0] syscall_funct,
  input  logic [31:0] syscall_param1,
  output logic        stall,
  output logic        print_valid,
  input  logic        print_ready,
  output logic [31:0] print_data,
  output logic        print_is_char,
  output logic        syscall_done,
  output logic        halted,
  output logic        bad_syscall
);

  localparam logic [31:0] FUNCT_PRINT_INT  = 32'd1;
  localparam logic [31:0] FUNCT_EXIT       = 32'd10;
  localparam logic [31:0] FUNCT_PRINT_CHAR = 32'd11;
  localparam logic [2:0]  CNT_LOAD         = 3'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_ISSUE,
    S_DONE,
    S_HALT
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] funct_q, param_q;
  logic [2:0]  cnt_q;
  logic        bad_q;
  logic        drain_end;
  logic        is_char;
  logic        decode_bad;

  // The capture cycle already counts as one drain cycle, so DRAIN ends in
  // the cycle where the counter reaches zero by its decrement. This gives an
  // IDLE-to-DONE latency of DRAIN_CYCLES+1 for a ready console.
  assign drain_end = (cnt_q <= 3'd1);

`ifdef SYSCALL_PRINT_CHAR_EN
  assign is_char = (funct_q == FUNCT_PRINT_CHAR);
`else
  assign is_char = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    decode_bad = 1'b0;
    case (state_q)
      S_IDLE:  if (is_syscall) state_d = S_DRAIN;
      S_DRAIN: begin
        if (drain_end) begin
          if (funct_q == FUNCT_PRINT_INT || is_char) begin
            state_d = S_ISSUE;
          end else if (funct_q == FUNCT_EXIT) begin
            state_d = S_HALT;
          end else begin
            state_d    = S_DONE;
            decode_bad = 1'b1;
          end
        end
      end
      S_ISSUE: if (print_ready) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    // rst_n gates the capture-cycle term so stall stays low during reset
    // even with a syscall present in EX.
    stall         = rst_n && ((state_q != S_IDLE && state_q != S_DONE) ||
                              (state_q == S_IDLE && is_syscall));
    print_valid   = (state_q == S_ISSUE);
    print_is_char = (state_q == S_ISSUE) && is_char;
    print_data    = 32'd0;
    if (state_q == S_ISSUE) print_data = is_char ? {24'd0, param_q[7:0]} : param_q;
    syscall_done  = (state_q == S_DONE);
    halted        = (state_q == S_HALT);
    bad_syscall   = bad_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      funct_q <= 32'd0;
      param_q <= 32'd0;
      cnt_q   <= 3'd0;
      bad_q   <= 1'b0;
    end else begin
      if (state_q == S_IDLE && is_syscall) begin
        funct_q <= syscall_funct;
        param_q <= syscall_param1;
        cnt_q   <= CNT_LOAD;
      end else if (state_q == S_DRAIN && cnt_q != 3'd0) begin
        cnt_q <= cnt_q - 3'd1;
      end
      if (decode_bad) bad_q <= 1'b1;
    end
  end

endmodule

// File: doc/syscall_controller.md
SYSCALL_CONTROLLER -- requirements
Module: syscall_controller

Interface
REQ-001 Parameter DRAIN_CYCLES, default 2: cycles to wait after capture so older instructions retire through MEM/WB. Legal range 1..7.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 is_syscall  input  1  SYSCALL instruction currently occupies EX.
REQ-005 syscall_funct  input  32  $v0 value forwarded to EX.
REQ-006 syscall_param1  input  32  $a0 value forwarded to EX.
REQ-007 stall  output  1  holds IF/ID/EX; MEM/WB continue.
REQ-008 print_valid  output  1  console request valid.
REQ-009 print_ready  input  1  console accepts the request.
REQ-010 print_data  output  32  value to print.
REQ-011 print_is_char  output  1  0 = signed decimal integer; 1 = low byte as ASCII.
REQ-012 syscall_done  output  1  one-cycle pulse when a syscall retires.
REQ-013 halted  output  1  program exited; sticky until reset.
REQ-014 bad_syscall  output  1  sticky flag: unsupported funct seen.

Function
REQ-015 Codes: PRINT_INT = 1, EXIT = 10, PRINT_CHAR = 11 (see REQ-031).
REQ-016 FSM states: IDLE, DRAIN, ISSUE, DONE, HALT.
REQ-017 IDLE with is_syscall=1: latch funct/param into internal regs, load drain counter with DRAIN_CYCLES-1, go to DRAIN.
REQ-018 stall = (state != IDLE and state != DONE) or (state == IDLE and is_syscall); this is combinational, so stall asserts in the capture cycle.
REQ-019 DRAIN: counter decrements each cycle. When the counter is 0, decode the latched funct:
- PRINT_INT -> ISSUE
- EXIT -> HALT
- any other value -> DONE, and set bad_syscall.
REQ-020 ISSUE:
- print_valid=1.
- print_data = latched param1; print_is_char is per funct.
- Both are held stable until print_valid and print_ready are high in the same cycle, then go to DONE.
- print_ready is ignored outside ISSUE.
REQ-021 print_ready already high on ISSUE entry completes the transfer in one cycle; exactly one transfer per syscall.
REQ-022 DONE: stall=0, syscall_done=1 for exactly one cycle, then go to IDLE. is_syscall is ignored in DONE, because the same instruction is leaving EX.
REQ-023 HALT: halted=1, stall=1, print_valid=0; the FSM never leaves HALT except by reset.
REQ-024 After entering DRAIN, changes on is_syscall, syscall_funct and syscall_param1 have no effect; only the latched copies are used.
REQ-025 Back-to-back syscalls: a syscall arriving in EX the cycle after DONE is captured normally from IDLE.
REQ-026 Minimum IDLE-to-DONE latency for PRINT_INT with print_ready=1 is DRAIN_CYCLES+1 cycles.

Reset
REQ-027 rst_n low immediately forces state=IDLE and clears the internal regs and the counter.
REQ-028 Outputs while rst_n is low: stall=0, print_valid=0, print_data=0, print_is_char=0, syscall_done=0, halted=0, bad_syscall=0.
REQ-029 Reset asserted mid-ISSUE drops print_valid asynchronously; the pending print is discarded, not replayed.
REQ-030 Reset deassertion is assumed synchronised externally; the first edge after release evaluates IDLE.

Configuration
REQ-031 Macro SYSCALL_PRINT_CHAR_EN:
- Defined: funct 11 -> ISSUE with print_is_char=1 and print_data = {24'b0, param1[7:0]}.
- Undefined: funct 11 is unsupported (DONE + bad_syscall), and print_is_char is tied to 0.

Verification
REQ-032 PRINT_INT, param1=0xFFFFFFF9, DRAIN_CYCLES=2, print_ready=1 -> stall asserted 3 cycles, print_valid 1 cycle with print_data=0xFFFFFFF9, print_is_char=0, syscall_done pulse in the 4th cycle.
REQ-033 PRINT_INT with print_ready held low 5 cycles after ISSUE entry -> print_valid high 6 cycles, print_data stable, stall high throughout, single syscall_done.
REQ-034 EXIT (funct=10) -> halted=1 and stall=1 permanently; a later is_syscall with funct=1 produces no print_valid; rst_n low clears halted.
REQ-035 funct=4 -> bad_syscall=1 sticky, no print_valid, syscall_done pulses; funct=11 behaves per REQ-031 in both macro builds (param1=0x12345641 -> print_data=0x41 when defined).
REQ-036 rst_n pulsed low during ISSUE -> print_valid and stall drop immediately; after release a new PRINT_INT completes normally.
REQ-037 Two syscalls separated by exactly one DONE cycle (funct 1, param 7 then 9) -> two transfers, in order 7 then 9, two syscall_done pulses.
